// File: rtl/tile_averager.sv
// Reduces one captured frame to a grid of 8x8 tile averages, emitted in raster order.
// Build option: define TILE_AVG_ROUND_EN to round averages half-up instead of truncating.
module tile_averager #(
  parameter int X0        = 200,
  parameter int Y0        = 250,
  parameter int IMG_W     = 320,
  parameter int IMG_H     = 240,
  parameter int TILE_LOG2 = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_in,
  input  logic [10:0] hcount_in,
  input  logic [9:0]  vcount_in,
  input  logic [3:0]  pixel_in,
  output logic        busy_out,
  output logic        tile_valid_out,
  output logic [3:0]  tile_avg_out,
  output logic [5:0]  tile_x_out,
  output logic [4:0]  tile_y_out,
  output logic        frame_done_out
);

  localparam int TILES_X = IMG_W >> TILE_LOG2;
  localparam int TILES_Y = IMG_H >> TILE_LOG2;
  localparam int SHIFT   = 2 * TILE_LOG2;
  localparam int ACC_W   = 4 + SHIFT;

  localparam logic [10:0] X_LO = 11'(X0);
  localparam logic [10:0] X_HI = 11'(X0 + IMG_W);
  localparam logic [9:0]  Y_LO = 10'(Y0);
  localparam logic [9:0]  Y_HI = 10'(Y0 + IMG_H);
  localparam logic [TILE_LOG2-1:0] SUB_LAST = '1;
  localparam logic [5:0] TX_LAST = 6'(TILES_X - 1);
  localparam logic [4:0] TY_LAST = 5'(TILES_Y - 1);

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    CAPTURE,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [10:0] rx;
  logic [9:0]  ry;
  logic [5:0]  tx;
  logic [4:0]  ty;
  logic        in_win;
  logic        origin;
  logic        tile_first;
  logic        tile_last;
  logic        frame_last;
  logic        cap_en;
  logic [ACC_W-1:0] acc [TILES_X];
  logic [ACC_W-1:0] sum;
  logic [3:0]       avg;

  assign in_win = (hcount_in >= X_LO) && (hcount_in < X_HI) &&
                  (vcount_in >= Y_LO) && (vcount_in < Y_HI);
  assign rx = hcount_in - X_LO;
  assign ry = vcount_in - Y_LO;
  assign tx = 6'(rx >> TILE_LOG2);
  assign ty = 5'(ry >> TILE_LOG2);

  assign tile_first = (rx[TILE_LOG2-1:0] == '0) &&
                      (ry[TILE_LOG2-1:0] == '0);
  assign tile_last  = (rx[TILE_LOG2-1:0] == SUB_LAST) &&
                      (ry[TILE_LOG2-1:0] == SUB_LAST);
  assign origin     = in_win && (rx == '0) && (ry == '0);
  assign frame_last = tile_last && (tx == TX_LAST) && (ty == TY_LAST);

  assign sum = acc[tx] + ACC_W'(pixel_in);

`ifdef TILE_AVG_ROUND_EN
  logic [ACC_W:0] rnd;
  assign rnd = {1'b0, sum} + (ACC_W + 1)'(1 << (SHIFT - 1));
  assign avg = 4'(rnd >> SHIFT);
`else
  assign avg = 4'(sum >> SHIFT);
`endif

  // DONE holds off one cycle so a start alongside frame_done is dropped
  always_comb begin
    state_d = state_q;
    cap_en  = 1'b0;
    unique case (state_q)
      IDLE:    if (start_in) state_d = ARM;
      ARM: begin
        if (origin) begin
          state_d = CAPTURE;
          cap_en  = 1'b1;
        end
      end
      CAPTURE: begin
        cap_en = in_win;
        if (in_win && frame_last) state_d = DONE;
      end
      DONE:    state_d = IDLE;
    endcase
  end

  assign busy_out = (state_q == ARM) || (state_q == CAPTURE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // First pixel of a tile overwrites the column slot, so no clear pass
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < TILES_X; i++) acc[i] <= '0;
    end else if (cap_en) begin
      acc[tx] <= tile_first ? ACC_W'(pixel_in) : sum;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tile_valid_out <= 1'b0;
      frame_done_out <= 1'b0;
      tile_avg_out   <= '0;
      tile_x_out     <= '0;
      tile_y_out     <= '0;
    end else begin
      tile_valid_out <= cap_en && tile_last;
      frame_done_out <= cap_en && frame_last;
      if (cap_en && tile_last) begin
        tile_avg_out <= avg;
        tile_x_out   <= tx;
        tile_y_out   <= ty;
      end
    end
  end

endmodule

// File: tb/tb_tile_averager.sv
// Directed bench for tile_averager on a 320x16 window (40x2 tiles).
// Blanking is trimmed to a few samples per line to keep frames short.
module tb_tile_averager;

  localparam int X0    = 200;
  localparam int Y0    = 250;
  localparam int IMG_W = 320;
  localparam int IMG_H = 16;
  localparam int TX    = IMG_W / 8;
  localparam int TY    = IMG_H / 8;
  localparam int NT    = TX * TY;
  localparam int H_BEG = X0 - 2;
  localparam int H_END = X0 + IMG_W + 1;
  localparam int V_BEG = Y0 - 1;
  localparam int V_END = Y0 + IMG_H;

  localparam int UNI   = 0;
  localparam int NOISE = 1;
  localparam int PAT   = 2;
  localparam int RND   = 3;

`ifdef TILE_AVG_ROUND_EN
  localparam int R_T0 = 1;
  localparam int R_T3 = 2;
`else
  localparam int R_T0 = 0;
  localparam int R_T3 = 1;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic [3:0]  pixel;
  logic        busy;
  logic        tile_valid;
  logic [3:0]  tile_avg;
  logic [5:0]  tile_x;
  logic [4:0]  tile_y;
  logic        frame_done;

  tile_averager #(
    .X0(X0), .Y0(Y0), .IMG_W(IMG_W), .IMG_H(IMG_H), .TILE_LOG2(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start_in(start),
    .hcount_in(hcount),
    .vcount_in(vcount),
    .pixel_in(pixel),
    .busy_out(busy),
    .tile_valid_out(tile_valid),
    .tile_avg_out(tile_avg),
    .tile_x_out(tile_x),
    .tile_y_out(tile_y),
    .frame_done_out(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int x;
    int y;
    int avg;
    bit done;
    int h;
    int v;
  } pulse_t;

  pulse_t pq[$];
  int n_cmp = 0;
  int n_err = 0;
  int done_cnt;
  bit done_seen;
  int busy_after;

  task automatic clear_rec();
    pq.delete();
    done_cnt   = 0;
    done_seen  = 1'b0;
    busy_after = -1;
  endtask

  task automatic step(input int h, input int v,
                      input logic [3:0] p, input logic st);
    @(negedge clk);
    hcount = 11'(h);
    vcount = 10'(v);
    pixel  = p;
    start  = st;
    @(posedge clk);
    #1;
    if (done_seen) begin
      busy_after = int'(busy);
      done_seen  = 1'b0;
    end
    if (tile_valid)
      pq.push_back('{int'(tile_x), int'(tile_y), int'(tile_avg),
                     frame_done, h, v});
    if (frame_done) begin
      done_cnt++;
      done_seen = 1'b1;
    end
  endtask

  function automatic logic [3:0] pix(input int mode, input int h,
                                     input int v);
    int rx;
    int ry;
    bit in_w;
    rx   = h - X0;
    ry   = v - Y0;
    in_w = rx >= 0 && rx < IMG_W && ry >= 0 && ry < IMG_H;
    case (mode)
      UNI:   return in_w ? 4'd15 : 4'd0;
      NOISE: return in_w ? 4'd0 : 4'd15;
      PAT:   return in_w ? 4'((rx / 8) % 16) : 4'd15;
      default: begin
        if (!in_w) return 4'd15;
        if (ry != 0) return 4'd0;
        case (rx / 8)
          0:       return 4'd4;
          1:       return (rx % 8 == 7) ? 4'd3 : 4'd4;
          3:       return 4'd12;
          default: return 4'd0;
        endcase
      end
    endcase
  endfunction

  task automatic run_lines(input int mode, input int v_lo, input int v_hi,
                           input int s1v, input int s1h,
                           input int s2v, input int s2h);
    for (int v = v_lo; v <= v_hi; v++)
      for (int h = H_BEG; h <= H_END; h++)
        step(h, v, pix(mode, h, v),
             (v == s1v && h == s1h) || (v == s2v && h == s2h));
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_busy got=%b want=0", busy);
    end
    n_cmp++;
    if (tile_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_valid got=%b want=0", tile_valid);
    end
    n_cmp++;
    if (tile_avg !== 4'd0) begin
      n_err++;
      $display("FAIL reset_avg got=%0d want=0", tile_avg);
    end
    n_cmp++;
    if ({tile_x, tile_y} !== 11'd0) begin
      n_err++;
      $display("FAIL reset_xy got=%0d,%0d want=0,0", tile_x, tile_y);
    end
    n_cmp++;
    if (frame_done !== 1'b0) begin
      n_err++;
      $display("FAIL reset_done got=%b want=0", frame_done);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_uniform();
    clear_rec();
    run_lines(UNI, V_BEG, V_END, V_BEG, H_BEG, -1, -1);
    n_cmp++;
    if (pq.size() !== NT) begin
      n_err++;
      $display("FAIL uniform_count got=%0d want=%0d", pq.size(), NT);
    end
    foreach (pq[i]) begin
      n_cmp++;
      if (pq[i].x !== i % TX || pq[i].y !== i / TX || pq[i].avg !== 15 ||
          pq[i].done !== (i == NT - 1)) begin
        n_err++;
        $display("FAIL uniform_tile[%0d] got x=%0d y=%0d avg=%0d done=%0d want x=%0d y=%0d avg=15 done=%0d",
                 i, pq[i].x, pq[i].y, pq[i].avg, pq[i].done,
                 i % TX, i / TX, i == NT - 1);
      end
    end
    n_cmp++;
    if (done_cnt !== 1) begin
      n_err++;
      $display("FAIL uniform_done_count got=%0d want=1", done_cnt);
    end
    n_cmp++;
    if (busy_after !== 0) begin
      n_err++;
      $display("FAIL uniform_busy_after_done got=%0d want=0", busy_after);
    end
  endtask

  task automatic test_noise();
    clear_rec();
    run_lines(NOISE, V_BEG, V_END, V_BEG, H_BEG, -1, -1);
    n_cmp++;
    if (pq.size() !== NT) begin
      n_err++;
      $display("FAIL noise_count got=%0d want=%0d", pq.size(), NT);
    end
    foreach (pq[i]) begin
      n_cmp++;
      if (pq[i].avg !== 0 || pq[i].x !== i % TX || pq[i].y !== i / TX) begin
        n_err++;
        $display("FAIL noise_tile[%0d] got x=%0d y=%0d avg=%0d want x=%0d y=%0d avg=0",
                 i, pq[i].x, pq[i].y, pq[i].avg, i % TX, i / TX);
      end
    end
  endtask

  task automatic test_pattern();
    clear_rec();
    run_lines(PAT, V_BEG, V_END, V_BEG, H_BEG, -1, -1);
    n_cmp++;
    if (pq.size() !== NT) begin
      n_err++;
      $display("FAIL pattern_count got=%0d want=%0d", pq.size(), NT);
    end
    foreach (pq[i]) begin
      n_cmp++;
      if (pq[i].avg !== (i % TX) % 16 || pq[i].x !== i % TX ||
          pq[i].y !== i / TX) begin
        n_err++;
        $display("FAIL pattern_tile[%0d] got x=%0d y=%0d avg=%0d want x=%0d y=%0d avg=%0d",
                 i, pq[i].x, pq[i].y, pq[i].avg,
                 i % TX, i / TX, (i % TX) % 16);
      end
    end
    n_cmp++;
    if (pq.size() < 2) begin
      n_err++;
      $display("FAIL pattern_latency got=%0d pulses want>=2", pq.size());
    end else begin
      if (pq[0].h !== X0 + 7 || pq[0].v !== Y0 + 7) begin
        n_err++;
        $display("FAIL pattern_latency got h=%0d v=%0d want h=%0d v=%0d",
                 pq[0].h, pq[0].v, X0 + 7, Y0 + 7);
      end
      n_cmp++;
      if (pq[1].h - pq[0].h !== 8) begin
        n_err++;
        $display("FAIL pattern_spacing got=%0d want=8", pq[1].h - pq[0].h);
      end
    end
  endtask

  task automatic test_mid_frame();
    clear_rec();
    run_lines(UNI, Y0 + 5, V_END, Y0 + 5, H_BEG, -1, -1);
    n_cmp++;
    if (pq.size() !== 0) begin
      n_err++;
      $display("FAIL midstart_partial got=%0d pulses want=0", pq.size());
    end
    n_cmp++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL midstart_armed_busy got=%b want=1", busy);
    end
    clear_rec();
    run_lines(UNI, V_BEG, V_END, Y0 + 3, H_BEG,
              Y0 + IMG_H - 1, X0 + IMG_W);
    n_cmp++;
    if (pq.size() !== NT || done_cnt !== 1) begin
      n_err++;
      $display("FAIL midstart_next_frame got=%0d pulses %0d done want=%0d pulses 1 done",
               pq.size(), done_cnt, NT);
    end
    n_cmp++;
    if (busy_after !== 0) begin
      n_err++;
      $display("FAIL midstart_busy_after_done got=%0d want=0", busy_after);
    end
    clear_rec();
    run_lines(UNI, V_BEG, Y0 + 8, -1, -1, -1, -1);
    n_cmp++;
    if (pq.size() !== 0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL midstart_no_rearm got=%0d pulses busy=%b want=0 pulses busy=0",
               pq.size(), busy);
    end
  endtask

  task automatic test_reset_mid();
    clear_rec();
    run_lines(PAT, V_BEG, Y0 + 9, V_BEG, H_BEG, -1, -1);
    n_cmp++;
    if (pq.size() !== TX) begin
      n_err++;
      $display("FAIL rstmid_pre_count got=%0d want=%0d", pq.size(), TX);
    end
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({busy, tile_valid, tile_avg, tile_x, tile_y, frame_done} !== 18'd0) begin
      n_err++;
      $display("FAIL rstmid_outputs got busy=%b v=%b avg=%0d x=%0d y=%0d done=%b want all 0",
               busy, tile_valid, tile_avg, tile_x, tile_y, frame_done);
    end
    @(negedge clk);
    rst = 1'b0;
    clear_rec();
    run_lines(PAT, Y0 + 10, V_END, -1, -1, -1, -1);
    run_lines(PAT, V_BEG, Y0 + 8, -1, -1, -1, -1);
    n_cmp++;
    if (pq.size() !== 0 || done_cnt !== 0) begin
      n_err++;
      $display("FAIL rstmid_no_pulses got=%0d pulses %0d done want=0",
               pq.size(), done_cnt);
    end
    clear_rec();
    run_lines(PAT, V_BEG, V_END, V_BEG, H_BEG, -1, -1);
    n_cmp++;
    if (pq.size() !== NT || done_cnt !== 1) begin
      n_err++;
      $display("FAIL rstmid_clean_count got=%0d pulses %0d done want=%0d pulses 1 done",
               pq.size(), done_cnt, NT);
    end
    foreach (pq[i]) begin
      n_cmp++;
      if (pq[i].avg !== (i % TX) % 16 || pq[i].x !== i % TX ||
          pq[i].y !== i / TX) begin
        n_err++;
        $display("FAIL rstmid_tile[%0d] got x=%0d y=%0d avg=%0d want x=%0d y=%0d avg=%0d",
                 i, pq[i].x, pq[i].y, pq[i].avg,
                 i % TX, i / TX, (i % TX) % 16);
      end
    end
  endtask

  task automatic test_round();
    clear_rec();
    run_lines(RND, V_BEG, V_END, V_BEG, H_BEG, -1, -1);
    n_cmp++;
    if (pq.size() < 4) begin
      n_err++;
      $display("FAIL round_count got=%0d want=%0d", pq.size(), NT);
    end else begin
      if (pq[0].avg !== R_T0) begin
        n_err++;
        $display("FAIL round_sum32 got=%0d want=%0d", pq[0].avg, R_T0);
      end
      n_cmp++;
      if (pq[1].avg !== 0) begin
        n_err++;
        $display("FAIL round_sum31 got=%0d want=0", pq[1].avg);
      end
      n_cmp++;
      if (pq[2].avg !== 0) begin
        n_err++;
        $display("FAIL round_sum0 got=%0d want=0", pq[2].avg);
      end
      n_cmp++;
      if (pq[3].avg !== R_T3) begin
        n_err++;
        $display("FAIL round_sum96 got=%0d want=%0d", pq[3].avg, R_T3);
      end
    end
  endtask

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    hcount = '0;
    vcount = '0;
    pixel  = '0;
    test_reset();
    test_uniform();
    test_noise();
    test_pattern();
    test_mid_frame();
    test_reset_mid();
    test_round();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
